// File: rtl/pkt_buf_pkg.sv
// Shared types and constants for the MAC packet-buffer read side.
// Word layout: [35]=SOP, [34]=EOP, [33:32]=BN (0 means 4 bytes), [31:0]=data.
package pkt_buf_pkg;

   localparam int unsigned DATA_WIDTH    = 36;
   localparam int unsigned ADDR_WIDTH    = 9;
   localparam int unsigned PTR_WIDTH     = ADDR_WIDTH + 1;
   localparam int unsigned FCNT_WIDTH    = ADDR_WIDTH + 1;
   localparam int unsigned PAYLOAD_WIDTH = 32;
   localparam int unsigned BN_WIDTH      = 2;

   localparam int unsigned SOP_BIT = 35;
   localparam int unsigned EOP_BIT = 34;
   localparam int unsigned BN_MSB  = 33;
   localparam int unsigned BN_LSB  = 32;

   typedef logic [PTR_WIDTH-1:0]  ptr_t;
   typedef logic [FCNT_WIDTH-1:0] fcnt_t;

   localparam fcnt_t FCNT_MAX = {FCNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_e;

   // Field order mirrors the RAM word so a plain cast unpacks it.
   typedef struct packed {
      logic                     sop;
      logic                     eop;
      logic [BN_WIDTH-1:0]      bn;
      logic [PAYLOAD_WIDTH-1:0] data;
   } word_t;

   function automatic word_t unpack_word(input logic [DATA_WIDTH-1:0] q);
      word_t w;
      w.sop  = q[SOP_BIT];
      w.eop  = q[EOP_BIT];
      w.bn   = q[BN_MSB:BN_LSB];
      w.data = q[PAYLOAD_WIDTH-1:0];
      return w;
   endfunction

endpackage

// File: rtl/pkt_buf_reader_if.sv
// Valid/ready word stream from the packet-buffer reader toward the MAC transmit path.
interface pkt_buf_reader_if;
   import pkt_buf_pkg::*;

   logic [PAYLOAD_WIDTH-1:0] out_data;
   logic                     out_sop;
   logic                     out_eop;
   logic [BN_WIDTH-1:0]      out_bn;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output out_data, out_sop, out_eop, out_bn, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_sop, out_eop, out_bn, out_valid,
      output out_ready
   );

endinterface

// File: rtl/pkt_buf_out_reg.sv
// Single-entry valid/ready output register: clear beats load, load beats drain.
module pkt_buf_out_reg
   import pkt_buf_pkg::*;
(
   input  logic  Clk,
   input  logic  Reset,
   input  logic  load,
   input  logic  clear,
   input  logic  ready,
   input  word_t d,
   output word_t q,
   output logic  valid
);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pkt_buf_reader.sv
// Read-side controller of the packet buffer: walks committed frames out of the RAM's
// combinational port onto a valid/ready stream, with abort/flush and framing-fault flag.
module pkt_buf_reader
   import pkt_buf_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Reset,
   input  ptr_t                  wr_ptr,
   input  logic                  frame_commit,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output ptr_t                  rd_ptr,
   pkt_buf_reader_if.master      strm,
   input  logic                  abort,
   output fcnt_t                 frames_pending,
   output logic                  err
);

   state_e state, state_nxt;
   ptr_t   rd_ptr_nxt;
   fcnt_t  pending_nxt;
   logic   err_nxt;
   logic   eop_loaded, eop_loaded_nxt;
   logic   fetch, load, clear, frame_done;
   logic   buf_empty, load_slot, has_pending, eop_accept;
   word_t  q_word, o_word;
   logic   o_valid;

   assign q_word      = unpack_word(ram_q);
   assign ram_addr    = rd_ptr[ADDR_WIDTH-1:0];
   assign buf_empty   = (rd_ptr == wr_ptr);
   assign load_slot   = !o_valid || strm.out_ready;
   assign has_pending = (frames_pending != '0);
   assign eop_accept  = o_valid && strm.out_ready && o_word.eop;

   // Next state, fetch decision, error detection and frame accounting.
   always_comb begin
      state_nxt      = state;
      eop_loaded_nxt = eop_loaded;
      err_nxt        = err;
      pending_nxt    = frames_pending;
      fetch          = 1'b0;
      load           = 1'b0;
      clear          = 1'b0;
      frame_done     = 1'b0;

      unique case (state)
         IDLE: begin
            // First word goes straight into the output register from IDLE.
            if (has_pending && !buf_empty && load_slot) begin
               fetch          = 1'b1;
               load           = 1'b1;
               eop_loaded_nxt = q_word.eop;
               state_nxt      = STREAM;
               if (!q_word.sop) err_nxt = 1'b1;
            end
         end
         STREAM: begin
            if (abort) begin
               clear          = 1'b1;
               eop_loaded_nxt = 1'b0;
               if (o_valid && o_word.eop) begin
                  frame_done = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  state_nxt  = FLUSH;
               end
            end else if (eop_accept) begin
               frame_done     = 1'b1;
               eop_loaded_nxt = 1'b0;
               state_nxt      = IDLE;
            end else if (!eop_loaded) begin
               if (buf_empty) begin
                  if (has_pending) err_nxt = 1'b1;
               end else if (load_slot) begin
                  fetch          = 1'b1;
                  load           = 1'b1;
                  eop_loaded_nxt = q_word.eop;
                  if (q_word.sop) err_nxt = 1'b1;
               end
            end
         end
         FLUSH: begin
            if (buf_empty) begin
               if (has_pending) err_nxt = 1'b1;
            end else begin
               fetch = 1'b1;
               if (q_word.eop) begin
                  frame_done = 1'b1;
                  state_nxt  = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A commit and a completed frame in the same cycle cancel out.
      if (frame_commit && !frame_done) begin
         if (frames_pending == FCNT_MAX) err_nxt = 1'b1;
         else                            pending_nxt = frames_pending + fcnt_t'(1);
      end else if (frame_done && !frame_commit && has_pending) begin
         pending_nxt = frames_pending - fcnt_t'(1);
      end

      rd_ptr_nxt = fetch ? rd_ptr + ptr_t'(1) : rd_ptr;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state          <= IDLE;
         rd_ptr         <= '0;
         frames_pending <= '0;
         err            <= 1'b0;
         eop_loaded     <= 1'b0;
      end else begin
         state          <= state_nxt;
         rd_ptr         <= rd_ptr_nxt;
         frames_pending <= pending_nxt;
         err            <= err_nxt;
         eop_loaded     <= eop_loaded_nxt;
      end
   end

   pkt_buf_out_reg u_out_reg (
      .Clk   (Clk),
      .Reset (Reset),
      .load  (load),
      .clear (clear),
      .ready (strm.out_ready),
      .d     (q_word),
      .q     (o_word),
      .valid (o_valid)
   );

   assign strm.out_valid = o_valid;
   assign strm.out_sop   = o_word.sop;
   assign strm.out_eop   = o_word.eop;
   assign strm.out_bn    = o_word.bn;
   assign strm.out_data  = o_word.data;

endmodule

// File: tb/tb_pkt_buf_reader.sv
// Bench for pkt_buf_reader: directed scenarios plus randomized frames, checked against
// an in-bench queue of expected words with abort dropping the rest of the current frame.
module tb_pkt_buf_reader;
   import pkt_buf_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  wr_ptr;
   logic        frame_commit;
   logic [8:0]  ram_addr;
   logic [35:0] ram_q;
   logic [9:0]  rd_ptr;
   logic        abort;
   logic [9:0]  frames_pending;
   logic        err;

   pkt_buf_reader_if strm();

   logic [35:0] mem [512];
   assign ram_q = mem[ram_addr];

   always #5 Clk = ~Clk;

   pkt_buf_reader dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .wr_ptr         (wr_ptr),
      .frame_commit   (frame_commit),
      .ram_addr       (ram_addr),
      .ram_q          (ram_q),
      .rd_ptr         (rd_ptr),
      .strm           (strm),
      .abort          (abort),
      .frames_pending (frames_pending),
      .err            (err)
   );

   // Model state: expected words in stream order, position within the head frame.
   logic [35:0] exp_q [$];
   int          head_idx;
   bit          exp_err;
   int          accepted;
   int          n_cmp;
   int          n_bad;
   bit          mon_en;
   logic [8:0]  addr_log [$];
   logic        prev_valid, prev_ready, prev_abort;
   logic [35:0] prev_word;
   logic [9:0]  prev_rd;
   logic [8:0]  prev_addr;
   int          ready_mode;
   int          cyc;
   int          abort_target;
   bit          abort_rand;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin : monitor
      logic [35:0] act;
      logic [35:0] w;
      act = {strm.out_sop, strm.out_eop, strm.out_bn, strm.out_data};
      if (mon_en && !Reset) begin
         if (rd_ptr != prev_rd) begin
            check("rd_ptr_step", 10'(rd_ptr - prev_rd), 64'd1);
            addr_log.push_back(prev_addr);
         end
         if (prev_valid && !prev_ready && !prev_abort) begin
            check("hold_valid", strm.out_valid, 64'd1);
            check("hold_word", act, prev_word);
         end
         if (strm.out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", strm.out_valid, 64'd0);
            end else begin
               w = exp_q[0];
               if (head_idx == 0 && !w[35]) exp_err = 1'b1;
               check("word", act, w);
               if (abort) begin
                  while (exp_q.size() > 0) begin
                     w = exp_q.pop_front();
                     if (w[34]) break;
                  end
                  head_idx = 0;
               end else if (strm.out_ready) begin
                  void'(exp_q.pop_front());
                  head_idx = w[34] ? 0 : head_idx + 1;
                  accepted++;
               end
            end
         end
         check("err", err, exp_err);
      end
      prev_valid = strm.out_valid;
      prev_ready = strm.out_ready;
      prev_abort = abort;
      prev_word  = act;
      prev_rd    = rd_ptr;
      prev_addr  = ram_addr;
   end

   task automatic step();
      @(posedge Clk);
      #1;
      cyc++;
      frame_commit = 1'b0;
      abort        = 1'b0;
      case (ready_mode)
         0:       strm.out_ready = 1'b1;
         1:       strm.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         default: strm.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (strm.out_valid) begin
         if (abort_target >= 0 && head_idx == abort_target) begin
            abort        = 1'b1;
            abort_target = -1;
         end else if (abort_rand && $urandom_range(0, 24) == 0) begin
            abort = 1'b1;
         end
      end
   endtask

   task automatic send_frame(input int len, input logic [1:0] bn, input bit bad_sop);
      logic [35:0] w;
      int guard;
      guard = 0;
      while (int'(10'(wr_ptr - rd_ptr)) + len > 512 && guard < 4000) begin
         step();
         guard++;
      end
      check("space_wait", guard < 4000, 64'd1);
      for (int i = 0; i < len; i++) begin
         w = {1'((i == 0) && !bad_sop), 1'(i == len - 1),
              (i == len - 1) ? bn : 2'($urandom), 32'($urandom)};
         mem[9'(wr_ptr + 10'(i))] = w;
         exp_q.push_back(w);
      end
      wr_ptr       = wr_ptr + 10'(len);
      frame_commit = 1'b1;
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && guard < 6000) begin
         step();
         guard++;
      end
      check({name, "_drained"}, guard < 6000, 64'd1);
      step();
      step();
      step();
   endtask

   task automatic do_reset();
      mon_en       = 1'b0;
      Reset        = 1'b1;
      wr_ptr       = '0;
      frame_commit = 1'b0;
      abort        = 1'b0;
      exp_q.delete();
      head_idx     = 0;
      exp_err      = 1'b0;
      step();
      step();
      Reset = 1'b0;
      @(negedge Clk);
      mon_en = 1'b1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int vcount;
      int acc0;
      int exp_addr [6];
      exp_addr     = '{510, 511, 0, 1, 2, 3};
      n_cmp        = 0;
      n_bad        = 0;
      cyc          = 0;
      accepted     = 0;
      ready_mode   = 0;
      abort_target = -1;
      abort_rand   = 1'b0;
      strm.out_ready = 1'b1;
      Reset        = 1'b1;
      for (int a = 0; a < 512; a++) mem[a] = '0;

      // Reset values, then idle with nothing committed.
      do_reset();
      check("rst_valid", strm.out_valid, 64'd0);
      check("rst_sop_eop", {strm.out_sop, strm.out_eop}, 64'd0);
      check("rst_data", strm.out_data, 64'd0);
      check("rst_bn", strm.out_bn, 64'd0);
      check("rst_rd_ptr", rd_ptr, 64'd0);
      check("rst_pending", frames_pending, 64'd0);
      check("rst_err", err, 64'd0);
      vcount = 0;
      repeat (20) begin
         step();
         if (strm.out_valid) vcount++;
      end
      check("idle_no_valid", vcount, 64'd0);

      // Single 4-word frame, BN=2: valid two cycles after the commit.
      send_frame(4, 2'd2, 1'b0);
      step();
      check("lat_not_yet", strm.out_valid, 64'd0);
      check("pending_one", frames_pending, 64'd1);
      step();
      check("lat_valid", strm.out_valid, 64'd1);
      check("lat_sop", strm.out_sop, 64'd1);
      repeat (4) step();
      check("single_all_out", exp_q.size(), 64'd0);
      check("single_valid_low", strm.out_valid, 64'd0);
      check("single_pending0", frames_pending, 64'd0);
      check("single_rd_ptr", rd_ptr, 64'd4);

      // Backpressure with ready pattern 1,0,0,1.
      ready_mode = 1;
      send_frame(4, 2'd3, 1'b0);
      step();
      drain("backpressure");
      check("bp_rd_ptr", rd_ptr, 64'd8);
      check("bp_pending0", frames_pending, 64'd0);

      // Wrap: filler moves the pointer to 510, then a 6-word frame crosses the end.
      ready_mode = 0;
      send_frame(502, 2'd0, 1'b0);
      step();
      drain("filler");
      check("filler_rd_ptr", rd_ptr, 64'd510);
      addr_log.delete();
      send_frame(6, 2'd0, 1'b0);
      step();
      drain("wrap");
      check("wrap_rd_ptr", rd_ptr, 64'h204);
      check("wrap_addr_count", addr_log.size(), 64'd6);
      for (int i = 0; i < 6 && i < addr_log.size(); i++)
         check("wrap_addr", addr_log[i], 64'(exp_addr[i]));

      // Abort on the 2nd word of an 8-word frame, then a 3-word frame.
      acc0         = accepted;
      abort_target = 1;
      send_frame(8, 2'd1, 1'b0);
      step();
      send_frame(3, 2'd2, 1'b0);
      step();
      drain("abort");
      check("abort_accepted", accepted - acc0, 64'd4);
      check("abort_pending0", frames_pending, 64'd0);
      check("abort_err", err, 64'd0);
      check("abort_rd_ptr", rd_ptr, 64'h20F);

      // Commit arriving in the same cycle the EOP word is accepted.
      send_frame(4, 2'd3, 1'b0);
      vcount = 0;
      do begin
         step();
         vcount++;
      end while (!(strm.out_valid && strm.out_eop) && vcount < 50);
      check("eop_seen", vcount < 50, 64'd1);
      send_frame(2, 2'd1, 1'b0);
      step();
      check("simul_pending", frames_pending, 64'd1);
      drain("simul");
      check("simul_pending0", frames_pending, 64'd0);
      check("simul_rd_ptr", rd_ptr, 64'h215);

      // First word without SOP raises the sticky error.
      send_frame(3, 2'd1, 1'b1);
      step();
      drain("bad_sop");
      check("bad_sop_err", err, 64'd1);

      // Random frames, random ready and occasional abort.
      do_reset();
      check("rst2_err", err, 64'd0);
      check("rst2_rd_ptr", rd_ptr, 64'd0);
      ready_mode = 2;
      abort_rand = 1'b1;
      for (int f = 0; f < 60; f++) begin
         send_frame($urandom_range(1, 16), 2'($urandom), 1'b0);
         step();
         repeat ($urandom_range(0, 3)) step();
      end
      abort_rand = 1'b0;
      drain("random");
      check("rand_rd_ptr", rd_ptr, wr_ptr);
      check("rand_pending0", frames_pending, 64'd0);
      check("rand_err", err, 64'd0);
      check("rand_valid_low", strm.out_valid, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
